dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: m0 (CPU core, priority) and m1 (DMA/debug loader).
- Sits between the requesters and the data memory, which has a registered read (1-cycle latency) and byte-enabled writes.
- Fixed priority to m0, with a starvation guard that forces a grant to m1 after a bounded wait.
- At most one memory access per cycle. Read data is returned to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int DATA_ADDR_WIDTH_DEF = 10;
  localparam int WAITCNT_WIDTH       = 8;

  typedef enum logic {OWNER_M0, OWNER_M1} owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: fixed priority to the CPU (m0) with a
// starvation guard for the loader (m1), and read-data steering by owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int DATA_ADDR_WIDTH = DATA_ADDR_WIDTH_DEF,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       m0_req,
  input  logic                       m0_we,
  input  logic [DATA_ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH/8-1:0]    m0_byteEn,
  input  logic [DATA_WIDTH-1:0]      m0_wdata,
  output logic                       m0_gnt,
  output logic                       m0_rvalid,
  output logic [DATA_WIDTH-1:0]      m0_rdata,

  input  logic                       m1_req,
  input  logic                       m1_we,
  input  logic [DATA_ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH/8-1:0]    m1_byteEn,
  input  logic [DATA_WIDTH-1:0]      m1_wdata,
  output logic                       m1_gnt,
  output logic                       m1_rvalid,
  output logic [DATA_WIDTH-1:0]      m1_rdata,

  output logic                       mem_en,
  output logic                       mem_r,
  output logic                       mem_w,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0]    mem_byteEn,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  localparam logic [WAITCNT_WIDTH-1:0] LIMIT = WAITCNT_WIDTH'(STARVE_LIMIT);

  logic [WAITCNT_WIDTH-1:0] waitCnt_q, waitCnt_d;
  logic                     rdPending_q, rdPending_d;
  owner_t                   rdOwner_q, rdOwner_d;

  logic force1;
  logic weSel;

  // Grants are suppressed during reset so nothing reaches the memory.
  always_comb begin
    force1 = m1_req && (waitCnt_q >= LIMIT);
    m1_gnt = !rst && m1_req && (!m0_req || force1);
    m0_gnt = !rst && m0_req && !m1_gnt;
  end

  always_comb begin
    mem_en     = m0_gnt | m1_gnt;
    weSel      = m1_gnt ? m1_we : m0_we;
    mem_r      = mem_en & ~weSel;
    mem_w      = mem_en & weSel;
    mem_addr   = m1_gnt ? m1_addr  : m0_addr;
    mem_wdata  = m1_gnt ? m1_wdata : m0_wdata;
    mem_byteEn = '0;
    if (mem_en) begin
      mem_byteEn = m1_gnt ? m1_byteEn : m0_byteEn;
    end
  end

  always_comb begin
    waitCnt_d = '0;
    if (m1_req && !m1_gnt) begin
      waitCnt_d = (waitCnt_q == '1) ? waitCnt_q : waitCnt_q + 1'b1;
    end
    rdPending_d = mem_r;
    rdOwner_d   = rdOwner_q;
    if (mem_r) begin
      rdOwner_d = m1_gnt ? OWNER_M1 : OWNER_M0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_q   <= '0;
      rdPending_q <= 1'b0;
      rdOwner_q   <= OWNER_M0;
    end else begin
      waitCnt_q   <= waitCnt_d;
      rdPending_q <= rdPending_d;
      rdOwner_q   <= rdOwner_d;
    end
  end

  // Read data is shared; only the owner's rvalid qualifies it.
  always_comb begin
    m0_rvalid = !rst && rdPending_q && (rdOwner_q == OWNER_M0);
    m1_rvalid = !rst && rdPending_q && (rdOwner_q == OWNER_M1);
    m0_rdata  = mem_rdata;
    m1_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read, byte-write memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [3:0]  m0_byteEn, m1_byteEn;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_r, mem_w;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_byteEn;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] memArr [256];

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteEn(m0_byteEn),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteEn(m1_byteEn),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr),
    .mem_byteEn(mem_byteEn), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: writes land at the granting edge, reads return one cycle later.
  always @(posedge clk) begin
    if (mem_en && mem_w) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byteEn[b]) memArr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_en && mem_r) mem_rdata <= memArr[mem_addr[9:2]];
  end

  task automatic applyStimulus(input logic rq0, input logic we0, input logic [9:0] a0,
                               input logic [3:0] be0, input logic [31:0] wd0,
                               input logic rq1, input logic we1, input logic [9:0] a1,
                               input logic [3:0] be1, input logic [31:0] wd1);
    m0_req = rq0; m0_we = we0; m0_addr = a0; m0_byteEn = be0; m0_wdata = wd0;
    m1_req = rq1; m1_we = we1; m1_addr = a1; m1_byteEn = be1; m1_wdata = wd1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 10'h000, 4'h0, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
  endtask

  task automatic bothRead();
    applyStimulus(1, 0, 10'h000, 4'hF, 32'h0, 1, 0, 10'h004, 4'hF, 32'h0);
  endtask

  initial begin
    logic expM1, prevM1;
    for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
    memArr[0]    = 32'h11111111;
    memArr[1]    = 32'h22222222;
    memArr[4]    = 32'h12345678;
    memArr[8'h10] = 32'hDEADBEEF;

    // Reset held with both requesters active
    rst = 1'b1;
    bothRead();
    repeat (3) begin
      nextCycle();
      checkOutput("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
      checkOutput("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
      checkOutput("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    end
    rst = 1'b0;
    #1;

    // Full contention: m1 forced every fifth grant; reads return to the right owner
    prevM1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expM1 = (i == 4) || (i == 9);
      checkOutput("cont_m0_gnt", {31'b0, m0_gnt}, {31'b0, !expM1});
      checkOutput("cont_m1_gnt", {31'b0, m1_gnt}, {31'b0, expM1});
      checkOutput("cont_addr", {22'b0, mem_addr}, expM1 ? 32'h4 : 32'h0);
      if (i == 0) begin
        checkOutput("cont_rvalid0", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
      end else begin
        checkOutput("cont_rvalid", {30'b0, m1_rvalid, m0_rvalid}, prevM1 ? 32'd2 : 32'd1);
        checkOutput("cont_rdata", prevM1 ? m1_rdata : m0_rdata,
                    prevM1 ? 32'h22222222 : 32'h11111111);
      end
      prevM1 = expM1;
      nextCycle();
    end
    idle();
    #1;
    checkOutput("tail_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    checkOutput("tail_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    checkOutput("tail_rdata", m1_rdata, 32'h22222222);
    checkOutput("idle_mem_en", {31'b0, mem_en}, 32'd0);
    checkOutput("idle_byteEn", {28'b0, mem_byteEn}, 32'd0);

    // m1 alone reads 0x040
    nextCycle();
    applyStimulus(0, 0, 10'h000, 4'h0, 32'h0, 1, 0, 10'h040, 4'hF, 32'h0);
    #1;
    checkOutput("m1only_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
    checkOutput("m1only_rw", {30'b0, mem_r, mem_w}, 32'd2);
    checkOutput("m1only_addr", {22'b0, mem_addr}, 32'h40);
    nextCycle();
    idle();
    #1;
    checkOutput("m1only_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd2);
    checkOutput("m1only_rdata", m1_rdata, 32'hDEADBEEF);

    // Byte write then read-back of the same word
    nextCycle();
    applyStimulus(1, 1, 10'h010, 4'b0010, 32'h0000AB00, 0, 0, 10'h000, 4'h0, 32'h0);
    #1;
    checkOutput("wr_gnt", {31'b0, m0_gnt}, 32'd1);
    checkOutput("wr_rw", {30'b0, mem_r, mem_w}, 32'd1);
    checkOutput("wr_byteEn", {28'b0, mem_byteEn}, 32'h2);
    checkOutput("wr_wdata", mem_wdata, 32'h0000AB00);
    nextCycle();
    applyStimulus(1, 0, 10'h010, 4'hF, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
    #1;
    checkOutput("wr_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    checkOutput("rb_rw", {30'b0, mem_r, mem_w}, 32'd2);
    nextCycle();
    idle();
    #1;
    checkOutput("rb_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd1);
    checkOutput("rb_rdata", m0_rdata, 32'h1234AB78);

    // Dropping m1 for a cycle restarts its wait count
    nextCycle();
    bothRead();
    for (int j = 0; j < 3; j++) begin
      #1;
      checkOutput("drop_pre_m1_gnt", {31'b0, m1_gnt}, 32'd0);
      nextCycle();
    end
    applyStimulus(1, 0, 10'h000, 4'hF, 32'h0, 0, 0, 10'h004, 4'hF, 32'h0);
    #1;
    checkOutput("drop_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    nextCycle();
    bothRead();
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput("drop_post_m1_gnt", {31'b0, m1_gnt}, 32'd0);
      nextCycle();
    end
    #1;
    checkOutput("drop_forced_m1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);

    // Reset arriving while an m1 read is outstanding
    nextCycle();
    applyStimulus(0, 0, 10'h000, 4'h0, 32'h0, 1, 0, 10'h040, 4'hF, 32'h0);
    #1;
    checkOutput("rstmid_gnt", {31'b0, m1_gnt}, 32'd1);
    nextCycle();
    rst = 1'b1;
    idle();
    #1;
    checkOutput("rstmid_rvalid_in_rst", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rstmid_rvalid_after", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
